// File: rtl/usb_fs_rx_deser_if.sv
// Receive-side bundle from usb_fs_rx_deser to the packet-level protocol engine.
// master: the deserialiser drives it; slave: the protocol engine observes it.
interface usb_fs_rx_deser_if;
    logic       bit_strobe_o;
    logic       pkt_start_o;
    logic [3:0] pid_o;
    logic       rx_data_put_o;
    logic [7:0] rx_data_o;
    logic       pkt_end_o;
    logic       crc_error_o;
    logic       bitstuff_error_o;
    logic       pid_error_o;
    logic [7:0] err_count_o;

    modport master (
        output bit_strobe_o, pkt_start_o, pid_o, rx_data_put_o, rx_data_o,
               pkt_end_o, crc_error_o, bitstuff_error_o, pid_error_o, err_count_o
    );

    modport slave (
        input  bit_strobe_o, pkt_start_o, pid_o, rx_data_put_o, rx_data_o,
               pkt_end_o, crc_error_o, bitstuff_error_o, pid_error_o, err_count_o
    );
endinterface

// File: rtl/usb_fs_rx_deser.sv
// USB full-speed receive front end: 4x oversampled clock recovery, line decode,
// NRZI decode, bit unstuffing, sync/PID detection, byte deserialisation and
// CRC5/CRC16 residual checking.
// Optional: define USB_FS_RX_ERR_CNT_EN to build the saturating error counter
// behind err_count_o; otherwise err_count_o is tied to zero.
module usb_fs_rx_deser #(
    parameter int unsigned MaxPktBytes = 72
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic link_reset_i,
    input  logic cfg_pinflip_i,
    input  logic rx_enable_i,
    input  logic usb_dp_i,
    input  logic usb_dn_i,
    usb_fs_rx_deser_if.master rx
);

    localparam int unsigned ByteCntW = $clog2(MaxPktBytes + 1);
    localparam logic [ByteCntW-1:0] MaxBytes = ByteCntW'(MaxPktBytes);
    localparam logic [15:0] Crc16Init = 16'hFFFF;
    localparam logic [15:0] Crc16Poly = 16'h8005;
    localparam logic [15:0] Crc16Good = 16'h800D;
    localparam logic [4:0]  Crc5Init  = 5'h1F;
    localparam logic [4:0]  Crc5Poly  = 5'h05;
    localparam logic [4:0]  Crc5Good  = 5'h0C;

    typedef enum logic [1:0] {
        LS_SE0 = 2'd0,
        LS_J   = 2'd1,
        LS_K   = 2'd2
    } line_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_EOP  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    line_e                line_q, line_d, prev_q, prev_d, line_c;
    logic [1:0]           phase_q, phase_d;
    logic                 strobe_q, strobe_d;
    logic [7:0]           sr_q, sr_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           ones_q, ones_d;
    logic [ByteCntW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]          crc16_q, crc16_d;
    logic [4:0]           crc5_q, crc5_d;
    logic                 crc_err_q, crc_err_d;
    logic                 pid_err_q, pid_err_d;
    logic                 se0_seen_q, se0_seen_d;
    logic [3:0]           pid_q, pid_d;
    logic [7:0]           data_q, data_d;
    logic                 start_q, start_d;
    logic                 put_q, put_d;
    logic                 end_q, end_d;
    logic                 crc_flag_q, crc_flag_d;
    logic                 stuff_flag_q, stuff_flag_d;
    logic                 pid_flag_q, pid_flag_d;

    logic                 dp_c, dn_c;
    logic                 bit_c, stuff_c, crc_bad_c;
    logic [15:0]          crc16_step_c;
    logic [4:0]           crc5_step_c;

    // Pin swap and line-state decode; SE1 folds into SE0
    always_comb begin
        dp_c   = cfg_pinflip_i ? usb_dn_i : usb_dp_i;
        dn_c   = cfg_pinflip_i ? usb_dp_i : usb_dn_i;
        line_c = LS_SE0;
        if (dp_c && !dn_c) begin
            line_c = LS_J;
        end else if (!dp_c && dn_c) begin
            line_c = LS_K;
        end
    end

    // Next-state: clock recovery, NRZI/unstuff, packet FSM, CRC and outputs
    always_comb begin
        state_d      = state_q;
        line_d       = line_c;
        phase_d      = (line_c != line_q) ? 2'd0 : phase_q + 2'd1;
        strobe_d     = 1'b0;
        prev_d       = prev_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        ones_d       = ones_q;
        byte_cnt_d   = byte_cnt_q;
        crc16_d      = crc16_q;
        crc5_d       = crc5_q;
        crc_err_d    = crc_err_q;
        pid_err_d    = pid_err_q;
        se0_seen_d   = se0_seen_q;
        pid_d        = pid_q;
        data_d       = data_q;
        start_d      = 1'b0;
        put_d        = 1'b0;
        end_d        = 1'b0;
        crc_flag_d   = 1'b0;
        stuff_flag_d = 1'b0;
        pid_flag_d   = 1'b0;

        strobe_d     = (phase_d == 2'd1);
        bit_c        = (line_q == prev_q);
        stuff_c      = (ones_q == 3'd6);
        crc16_step_c = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ bit_c) ? Crc16Poly : 16'h0000);
        crc5_step_c  = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ bit_c) ? Crc5Poly : 5'h00);
        crc_bad_c    = ((pid_q[1:0] == 2'b11) && (crc16_q != Crc16Good)) ||
                       ((pid_q[1:0] == 2'b01) && (crc5_q != Crc5Good));

        if (strobe_q) begin
            // Idle bus after SE0 is J, so NRZI history restarts from J
            prev_d = (line_q == LS_SE0) ? LS_J : line_q;
            case (state_q)
                ST_IDLE: begin
                    if (rx_enable_i && line_q == LS_K) begin
                        state_d   = ST_SYNC;
                        sr_d      = {7'd0, bit_c};
                        bit_cnt_d = 4'd1;
                    end
                end
                ST_SYNC: begin
                    if (line_q == LS_SE0) begin
                        state_d = ST_IDLE;
                    end else begin
                        sr_d = {sr_q[6:0], bit_c};
                        if (sr_d[5:0] == 6'b000001 && bit_cnt_q >= 4'd5) begin
                            state_d    = ST_PID;
                            sr_d       = 8'h00;
                            bit_cnt_d  = 4'd0;
                            ones_d     = 3'd0;
                            crc_err_d  = 1'b0;
                            pid_err_d  = 1'b0;
                            se0_seen_d = 1'b0;
                        end else if (bit_cnt_q == 4'd8) begin
                            state_d = ST_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PID, ST_DATA: begin
                    if (line_q == LS_SE0) begin
                        state_d    = ST_EOP;
                        se0_seen_d = 1'b1;
                        if (state_q == ST_PID) begin
                            pid_err_d = 1'b1;
                        end else if (bit_cnt_q != 4'd0 || crc_bad_c) begin
                            crc_err_d = 1'b1;
                        end
                    end else if (stuff_c) begin
                        // Bit after six ones must be a stuffed zero
                        if (bit_c) begin
                            end_d        = 1'b1;
                            stuff_flag_d = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        ones_d = bit_c ? ones_q + 3'd1 : 3'd0;
                        sr_d   = {bit_c, sr_q[7:1]};
                        if (state_q == ST_PID) begin
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_d = 4'd0;
                                if (sr_d[7:4] == ~sr_d[3:0]) begin
                                    pid_d      = sr_d[3:0];
                                    start_d    = 1'b1;
                                    state_d    = ST_DATA;
                                    byte_cnt_d = '0;
                                    crc16_d    = Crc16Init;
                                    crc5_d     = Crc5Init;
                                end else begin
                                    pid_err_d = 1'b1;
                                    state_d   = ST_EOP;
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end else begin
                            crc16_d = crc16_step_c;
                            crc5_d  = crc5_step_c;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_d  = 4'd0;
                                put_d      = 1'b1;
                                data_d     = sr_d;
                                byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                                if (byte_cnt_d == MaxBytes) begin
                                    crc_err_d = 1'b1;
                                    state_d   = ST_EOP;
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (line_q == LS_SE0) begin
                        se0_seen_d = 1'b1;
                    end else if (line_q == LS_J && se0_seen_q) begin
                        end_d      = 1'b1;
                        crc_flag_d = crc_err_q;
                        pid_flag_d = pid_err_q;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Transmitter owns the bus: drop any packet in flight without reporting it
        if (!rx_enable_i) begin
            state_d      = ST_IDLE;
            start_d      = 1'b0;
            put_d        = 1'b0;
            end_d        = 1'b0;
            crc_flag_d   = 1'b0;
            stuff_flag_d = 1'b0;
            pid_flag_d   = 1'b0;
        end

        // USB reset wins over everything
        if (link_reset_i) begin
            state_d      = ST_IDLE;
            line_d       = LS_J;
            phase_d      = 2'd0;
            strobe_d     = 1'b0;
            prev_d       = LS_J;
            sr_d         = 8'h00;
            bit_cnt_d    = 4'd0;
            ones_d       = 3'd0;
            byte_cnt_d   = '0;
            crc16_d      = 16'h0000;
            crc5_d       = 5'h00;
            crc_err_d    = 1'b0;
            pid_err_d    = 1'b0;
            se0_seen_d   = 1'b0;
            pid_d        = 4'h0;
            data_d       = 8'h00;
            start_d      = 1'b0;
            put_d        = 1'b0;
            end_d        = 1'b0;
            crc_flag_d   = 1'b0;
            stuff_flag_d = 1'b0;
            pid_flag_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            line_q       <= LS_J;
            phase_q      <= 2'd0;
            strobe_q     <= 1'b0;
            prev_q       <= LS_J;
            sr_q         <= 8'h00;
            bit_cnt_q    <= 4'd0;
            ones_q       <= 3'd0;
            byte_cnt_q   <= '0;
            crc16_q      <= 16'h0000;
            crc5_q       <= 5'h00;
            crc_err_q    <= 1'b0;
            pid_err_q    <= 1'b0;
            se0_seen_q   <= 1'b0;
            pid_q        <= 4'h0;
            data_q       <= 8'h00;
            start_q      <= 1'b0;
            put_q        <= 1'b0;
            end_q        <= 1'b0;
            crc_flag_q   <= 1'b0;
            stuff_flag_q <= 1'b0;
            pid_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            phase_q      <= phase_d;
            strobe_q     <= strobe_d;
            prev_q       <= prev_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_q       <= ones_d;
            byte_cnt_q   <= byte_cnt_d;
            crc16_q      <= crc16_d;
            crc5_q       <= crc5_d;
            crc_err_q    <= crc_err_d;
            pid_err_q    <= pid_err_d;
            se0_seen_q   <= se0_seen_d;
            pid_q        <= pid_d;
            data_q       <= data_d;
            start_q      <= start_d;
            put_q        <= put_d;
            end_q        <= end_d;
            crc_flag_q   <= crc_flag_d;
            stuff_flag_q <= stuff_flag_d;
            pid_flag_q   <= pid_flag_d;
        end
    end

`ifdef USB_FS_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of packets that ended with any error flag
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (end_q && (crc_flag_q || stuff_flag_q || pid_flag_q) && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        if (link_reset_i) begin
            err_cnt_d = 8'h00;
        end
    end

    // Error counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rx.err_count_o = err_cnt_q;
`else
    assign rx.err_count_o = 8'h00;
`endif

    assign rx.bit_strobe_o     = strobe_q;
    assign rx.pkt_start_o      = start_q;
    assign rx.pid_o            = pid_q;
    assign rx.rx_data_put_o    = put_q;
    assign rx.rx_data_o        = data_q;
    assign rx.pkt_end_o        = end_q;
    assign rx.crc_error_o      = crc_flag_q;
    assign rx.bitstuff_error_o = stuff_flag_q;
    assign rx.pid_error_o      = pid_flag_q;

endmodule
